// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared FSM state type and length helpers for the serial pattern generator.
package seq_gen_pkg;

    typedef enum logic {IDLE, SEND} state_t;

    function automatic int lw_of(input int w);
        return $clog2(w) + 1;
    endfunction

    // A length of 0, or one longer than the pattern register, means a full-width pattern.
    function automatic int clamp_len(input int l, input int w);
        return (l == 0 || l > w) ? w : l;
    endfunction

endpackage

// File: rtl/seq_bit_cnt.sv
// seq_bit_cnt: per-frame bit down-counter; zero marks the bit currently on dout as the last.
module seq_bit_cnt #(
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [LW-1:0] load_val,
    input  logic          dec,
    output logic [LW-1:0] cnt,
    output logic          zero
);

    assign zero = cnt == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && !zero)
            cnt <= cnt - LW'(1);
    end

endmodule

// File: rtl/seq_gen_tx.sv
// seq_gen_tx: loads a pattern word and shifts it out MSB-first, once or looping until stopped.
module seq_gen_tx
    import seq_gen_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int LW    = lw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [LW-1:0]    len,
    input  logic             loop,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             stop,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             frame_last
);

    state_t           state, nxt;
    logic [WIDTH-1:0] pat, sh, aligned, sh_n;
    logic [LW-1:0]    len_c, plen, cnt, cnt_ld;
    logic             lp, stop_pend, zero, ld, fin, restart, adv, cnt_load;
    logic             dout_n, vld_n, start_n, last_n;

    // Pattern is left-aligned at capture so the first bit always leaves from the MSB.
    assign len_c    = LW'(clamp_len(int'(len), WIDTH));
    assign aligned  = din << (LW'(WIDTH) - len_c);
    assign ld       = state == IDLE && load_valid && load_ready;
    assign fin      = state == SEND && zero;
    assign restart  = fin && lp && !(stop_pend || stop);
    assign adv      = state == SEND && !zero;
    assign cnt_load = ld || restart;
    assign cnt_ld   = (ld ? len_c : plen) - LW'(1);

    seq_bit_cnt #(.LW(LW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_ld),
        .dec      (adv),
        .cnt      (cnt),
        .zero     (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state == IDLE ? (ld ? SEND : IDLE) : (fin && !restart ? IDLE : SEND);
    end

    always_comb begin
        dout_n  = ld ? aligned[WIDTH-1] : restart ? pat[WIDTH-1] : adv && sh[WIDTH-1];
        vld_n   = ld || restart || adv;
        start_n = ld || restart;
        last_n  = ld ? len_c == LW'(1) : restart ? plen == LW'(1) : adv && cnt == LW'(1);
        sh_n    = ld ? aligned << 1 : restart ? pat << 1 : sh << 1;
    end

    // A stop is held only while a frame is in flight; the frame boundary consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            load_ready  <= 1'b0;
            stop_pend   <= 1'b0;
            sh          <= '0;
            pat         <= '0;
            plen        <= '0;
            lp          <= 1'b0;
        end else begin
            dout        <= dout_n;
            dout_valid  <= vld_n;
            frame_start <= start_n;
            frame_last  <= last_n;
            load_ready  <= nxt == IDLE;
            stop_pend   <= state == SEND && !fin && (stop_pend || stop);
            sh          <= sh_n;
            if (ld) begin
                pat  <= aligned;
                plen <= len_c;
                lp   <= loop;
            end
        end
    end

endmodule
